remove_cyclic_prefix: RTL and testbench

//  Receive-side counterpart of the transmit CP inserter. Takes the 80-sample time-domain

---
 rtl/remove_cyclic_prefix_if.sv | 32 +++
 rtl/remove_cyclic_prefix.sv | 146 ++++++++++++++
 tb/tb_remove_cyclic_prefix.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/remove_cyclic_prefix_if.sv
// Sample-stream bundle between the timing-sync front end, the CP remover and the RX FFT.
// The master drives samples in and the slave (the CP remover) drives the framed body out.
interface remove_cyclic_prefix_if #(
  parameter int WIDTH = 18,
  parameter int IDX_W = 6,
  parameter int CNT_W = 8
);
  logic                    din_valid;
  logic                    sym_start;
  logic signed [WIDTH-1:0] rcp_real_din;
  logic signed [WIDTH-1:0] rcp_imag_din;
  logic                    dout_valid;
  logic                    dout_sop;
  logic                    dout_eop;
  logic [IDX_W-1:0]        dout_index;
  logic signed [WIDTH-1:0] rcp_real_dout;
  logic signed [WIDTH-1:0] rcp_imag_dout;
  logic                    sym_err;
  logic [CNT_W-1:0]        sym_cnt;

  modport master (
    output din_valid, sym_start, rcp_real_din, rcp_imag_din,
    input  dout_valid, dout_sop, dout_eop, dout_index,
    input  rcp_real_dout, rcp_imag_dout, sym_err, sym_cnt
  );

  modport slave (
    input  din_valid, sym_start, rcp_real_din, rcp_imag_din,
    output dout_valid, dout_sop, dout_eop, dout_index,
    output rcp_real_dout, rcp_imag_dout, sym_err, sym_cnt
  );
endinterface

// File: rtl/remove_cyclic_prefix.sv
// Receive CP remover: drops the CP_LEN prefix of each timing-synced OFDM symbol and
// forwards the N_FFT body with index/sop/eop framing, one clock of latency.
module remove_cyclic_prefix #(
  parameter int WIDTH  = 18,
  parameter int N_FFT  = 64,
  parameter int CP_LEN = 16,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 8
) (
  input logic                  rcp_clk,
  input logic                  rcp_rst,
  remove_cyclic_prefix_if.slave bus
);
  localparam int SYM_LEN = CP_LEN + N_FFT;
  localparam int POS_W   = $clog2(SYM_LEN);

  localparam logic [POS_W-1:0] CP_LAST    = POS_W'(CP_LEN - 1);
  localparam logic [POS_W-1:0] BODY_FIRST = POS_W'(CP_LEN);
  localparam logic [POS_W-1:0] SYM_LAST   = POS_W'(SYM_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CP,
    DATA
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [POS_W-1:0]   r_pos;
  logic [POS_W-1:0]   w_pos_nxt;
  logic               w_fwd;
  logic               w_eop;
  logic               w_err;
  logic               w_sop;
  logic [IDX_W-1:0]   w_body_idx;

  logic               r_dout_valid;
  logic               r_dout_sop;
  logic               r_dout_eop;
  logic [IDX_W-1:0]   r_dout_index;
  logic [WIDTH-1:0]   r_real_dout;
  logic [WIDTH-1:0]   r_imag_dout;
  logic               r_sym_err;
  logic [CNT_W-1:0]   r_sym_cnt;

  always_ff @(posedge rcp_clk or posedge rcp_rst) begin
    if (rcp_rst) begin
      r_state <= IDLE;
      r_pos   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  // A sym_start seen mid-symbol restarts framing: that sample becomes CP sample 0.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_fwd       = 1'b0;
    w_eop       = 1'b0;
    w_err       = 1'b0;
    if (bus.din_valid) begin
      case (r_state)
        IDLE: begin
          if (bus.sym_start) begin
            w_state_nxt = CP;
            w_pos_nxt   = POS_W'(1);
          end
        end
        CP: begin
          if (bus.sym_start && (r_pos != '0)) begin
            w_err     = 1'b1;
            w_pos_nxt = POS_W'(1);
          end else if (r_pos == CP_LAST) begin
            w_state_nxt = DATA;
            w_pos_nxt   = BODY_FIRST;
          end else begin
            w_pos_nxt = r_pos + 1'b1;
          end
        end
        DATA: begin
          if (bus.sym_start) begin
            w_err       = 1'b1;
            w_state_nxt = CP;
            w_pos_nxt   = POS_W'(1);
          end else begin
            w_fwd = 1'b1;
            if (r_pos == SYM_LAST) begin
              w_eop       = 1'b1;
              w_state_nxt = CP;
              w_pos_nxt   = '0;
            end else begin
              w_pos_nxt = r_pos + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_pos_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_body_idx = IDX_W'(r_pos - BODY_FIRST);
    w_sop      = w_fwd && (r_pos == BODY_FIRST);
  end

  // Data and index only load on forwarded samples so they hold across gaps.
  always_ff @(posedge rcp_clk or posedge rcp_rst) begin
    if (rcp_rst) begin
      r_dout_valid <= 1'b0;
      r_dout_sop   <= 1'b0;
      r_dout_eop   <= 1'b0;
      r_dout_index <= '0;
      r_real_dout  <= '0;
      r_imag_dout  <= '0;
      r_sym_err    <= 1'b0;
      r_sym_cnt    <= '0;
    end else begin
      r_dout_valid <= w_fwd;
      r_dout_sop   <= w_sop;
      r_dout_eop   <= w_eop;
      r_sym_err    <= w_err;
      if (w_fwd) begin
        r_dout_index <= w_body_idx;
        r_real_dout  <= bus.rcp_real_din;
        r_imag_dout  <= bus.rcp_imag_din;
      end
      if (w_eop) begin
        r_sym_cnt <= r_sym_cnt + 1'b1;
      end
    end
  end

  assign bus.dout_valid    = r_dout_valid;
  assign bus.dout_sop      = r_dout_sop;
  assign bus.dout_eop      = r_dout_eop;
  assign bus.dout_index    = r_dout_index;
  assign bus.rcp_real_dout = r_real_dout;
  assign bus.rcp_imag_dout = r_imag_dout;
  assign bus.sym_err       = r_sym_err;
  assign bus.sym_cnt       = r_sym_cnt;
endmodule

// File: tb/tb_remove_cyclic_prefix.sv
// Bench for remove_cyclic_prefix: symbol runs from a table plus hand sequences for
// realignment, pre-sync discard, async reset and counter wrap, scored against a queue.
module tb_remove_cyclic_prefix;
  localparam int W = 18;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  int   sample_k;
  logic [7:0] exp_cnt;
  bit   armed;

  typedef struct {
    int         due;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [5:0] idx;
    logic       sop;
    logic       eop;
  } exp_rec_t;

  typedef struct {
    int unsigned n_sym;
    bit          gaps;
    bit          start_each;
    bit          extreme;
    logic [7:0]  exp_cnt;
  } run_t;

  exp_rec_t q[$];
  int       errq[$];
  logic [W-1:0] last_re;
  logic [W-1:0] last_im;
  logic [5:0]   last_idx;

  remove_cyclic_prefix_if #(.WIDTH(W), .IDX_W(6), .CNT_W(8)) bus ();

  remove_cyclic_prefix #(
    .WIDTH(W), .N_FFT(64), .CP_LEN(16), .IDX_W(6), .CNT_W(8)
  ) dut (
    .rcp_clk(clk),
    .rcp_rst(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor / scoreboard
  always @(negedge clk) begin
    exp_rec_t e;
    bit exp_v;
    bit exp_e;
    while (q.size() > 0 && q[0].due < cyc) begin
      checks++; failures++;
      $display("FAIL missed_output idx=%0d due=%0d now=%0d", q[0].idx, q[0].due, cyc);
      void'(q.pop_front());
    end
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    if (bus.dout_valid === 1'b1 || exp_v) begin
      checks++;
      if (!exp_v) begin
        failures++;
        $display("FAIL unexpected_dout_valid got idx=%0d data=%h required dout_valid=0 (cyc %0d)",
                 bus.dout_index, bus.rcp_real_dout, cyc);
      end else begin
        e = q.pop_front();
        if (bus.dout_valid !== 1'b1 || bus.rcp_real_dout !== e.re || bus.rcp_imag_dout !== e.im ||
            bus.dout_index !== e.idx || bus.dout_sop !== e.sop || bus.dout_eop !== e.eop) begin
          failures++;
          $display("FAIL sample got v=%b re=%h im=%h idx=%0d sop=%b eop=%b required v=1 re=%h im=%h idx=%0d sop=%b eop=%b",
                   bus.dout_valid, bus.rcp_real_dout, bus.rcp_imag_dout, bus.dout_index,
                   bus.dout_sop, bus.dout_eop, e.re, e.im, e.idx, e.sop, e.eop);
        end
        last_re = e.re; last_im = e.im; last_idx = e.idx;
        if (e.eop) begin
          exp_cnt = exp_cnt + 8'd1;
          checks++;
          if (bus.sym_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL sym_cnt_at_eop got %0d required %0d", bus.sym_cnt, exp_cnt);
          end
        end
      end
    end else if (armed) begin
      checks++;
      if (bus.dout_sop !== 1'b0 || bus.dout_eop !== 1'b0 || bus.rcp_real_dout !== last_re ||
          bus.rcp_imag_dout !== last_im || bus.dout_index !== last_idx) begin
        failures++;
        $display("FAIL idle_hold got sop=%b eop=%b re=%h im=%h idx=%0d required sop=0 eop=0 re=%h im=%h idx=%0d",
                 bus.dout_sop, bus.dout_eop, bus.rcp_real_dout, bus.rcp_imag_dout, bus.dout_index,
                 last_re, last_im, last_idx);
      end
    end
    while (errq.size() > 0 && errq[0] < cyc) begin
      checks++; failures++;
      $display("FAIL missed_sym_err due=%0d now=%0d", errq[0], cyc);
      void'(errq.pop_front());
    end
    exp_e = (errq.size() > 0) && (errq[0] == cyc);
    if (bus.sym_err === 1'b1 || exp_e) begin
      checks++;
      if (bus.sym_err !== exp_e) begin
        failures++;
        $display("FAIL sym_err got %b required %b (cyc %0d)", bus.sym_err, exp_e, cyc);
      end
      if (exp_e) void'(errq.pop_front());
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if ({bus.dout_valid, bus.dout_sop, bus.dout_eop, bus.dout_index, bus.rcp_real_dout,
         bus.rcp_imag_dout, bus.sym_err, bus.sym_cnt} !== '0) begin
      failures++;
      $display("FAIL %s got v=%b sop=%b eop=%b idx=%0d re=%h im=%h err=%b cnt=%0d required all 0",
               name, bus.dout_valid, bus.dout_sop, bus.dout_eop, bus.dout_index,
               bus.rcp_real_dout, bus.rcp_imag_dout, bus.sym_err, bus.sym_cnt);
    end
  endtask

  task automatic check_cnt(input string name, input logic [7:0] req);
    checks++;
    if (bus.sym_cnt !== req) begin
      failures++;
      $display("FAIL %s sym_cnt got %0d required %0d", name, bus.sym_cnt, req);
    end
  endtask

  // Reset asserted between clock edges, so the zero check observes the async path.
  task automatic do_reset(input string name);
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.sym_start = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero(name);
    q.delete();
    errq.delete();
    exp_cnt  = '0;
    last_re  = '0; last_im = '0; last_idx = '0;
    armed    = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic st, input logic [W-1:0] re,
                       input logic [W-1:0] im, input bit exp_out, input int unsigned idx,
                       input bit exp_err);
    exp_rec_t e;
    @(negedge clk);
    bus.din_valid    = v;
    bus.sym_start    = st;
    bus.rcp_real_din = re;
    bus.rcp_imag_din = im;
    if (exp_out) begin
      e.due = cyc + 1; e.re = re; e.im = im; e.idx = 6'(idx);
      e.sop = (idx == 0); e.eop = (idx == 63);
      q.push_back(e);
    end
    if (exp_err) errq.push_back(cyc + 1);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic gen(input bit extreme, output logic [W-1:0] re, output logic [W-1:0] im);
    if (extreme) re = sample_k[0] ? 18'h1FFFF : 18'h20000;
    else         re = W'(sample_k);
    im = ~re;
    sample_k++;
  endtask

  task automatic drive_symbols(input int unsigned n_sym, input bit gaps, input bit start_each,
                               input bit first_start, input bit extreme, input bit err_first,
                               input bit synced);
    logic [W-1:0] re, im;
    bit st;
    for (int unsigned s = 0; s < n_sym; s++) begin
      for (int unsigned k = 0; k < 80; k++) begin
        gen(extreme, re, im);
        st = (k == 0) && (start_each || (s == 0 && first_start));
        drive(1'b1, st, re, im, synced && (k >= 16), k - 16, err_first && s == 0 && k == 0);
        if (gaps) drive(1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0, 0, 1'b0);
      end
    end
  endtask

  task automatic drive_prefix(input int unsigned n);
    logic [W-1:0] re, im;
    for (int unsigned k = 0; k < n; k++) begin
      gen(1'b0, re, im);
      drive(1'b1, k == 0, re, im, k >= 16, k - 16, 1'b0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    run_t runs[3];
    runs[0] = '{n_sym: 3, gaps: 1'b0, start_each: 1'b0, extreme: 1'b0, exp_cnt: 8'd3};
    runs[1] = '{n_sym: 3, gaps: 1'b1, start_each: 1'b1, extreme: 1'b0, exp_cnt: 8'd6};
    runs[2] = '{n_sym: 2, gaps: 1'b1, start_each: 1'b0, extreme: 1'b1, exp_cnt: 8'd8};

    cyc = 0; checks = 0; failures = 0; sample_k = 0; exp_cnt = '0; armed = 1'b0;
    rst = 1'b1;
    bus.din_valid = 1'b0; bus.sym_start = 1'b0;
    bus.rcp_real_din = '0; bus.rcp_imag_din = '0;

    // Contiguous, gapped and extreme-value symbol runs
    do_reset("reset_initial");
    for (int i = 0; i < 3; i++) begin
      drive_symbols(runs[i].n_sym, runs[i].gaps, runs[i].start_each, i == 0,
                    runs[i].extreme, 1'b0, 1'b1);
      idle(3);
      check_cnt($sformatf("run%0d", i), runs[i].exp_cnt);
    end

    // Realignment at body index 20 of symbol 2
    do_reset("reset_realign");
    sample_k = 0;
    drive_symbols(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_prefix(36);
    idle(3);
    check_cnt("realign_before", 8'd1);
    drive_symbols(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(3);
    check_cnt("realign_after", 8'd2);

    // Unsynced samples and an invalid sym_start are discarded
    do_reset("reset_presync");
    for (int i = 0; i < 50; i++) drive(1'b1, 1'b0, W'(i), W'(~i), 1'b0, 0, 1'b0);
    drive(1'b0, 1'b1, '0, '0, 1'b0, 0, 1'b0);
    drive_symbols(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check_cnt("presync_idle", 8'd0);
    drive_symbols(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    check_cnt("presync_synced", 8'd1);

    // Async reset at body index 30, then resync required
    drive_symbols(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_prefix(47);
    do_reset("reset_midsymbol");
    drive_symbols(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check_cnt("after_reset_nosync", 8'd0);
    drive_symbols(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    check_cnt("after_reset_sync", 8'd1);

    // Counter wrap with extreme data
    do_reset("reset_wrap");
    drive_symbols(255, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);
    check_cnt("wrap_255", 8'd255);
    drive_symbols(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    check_cnt("wrap_0", 8'd0);
    drive_symbols(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    check_cnt("wrap_1", 8'd1);

    idle(3);
    checks++;
    if (q.size() != 0 || errq.size() != 0) begin
      failures++;
      $display("FAIL drain pending got %0d samples %0d errs required 0", q.size(), errq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
